// File: rtl/alu_driver.sv
// alu_driver: initiator side of the ALU command/busy handshake with a busy timeout.
// Optional sticky overflow/carry accumulation is built when ALU_DRIVER_STICKY_FLAGS_EN is defined.

`ifndef aluCMDwidth
`define aluCMDwidth 5
`endif
`ifndef aluOFF
`define aluOFF 5'd0
`endif

// state | meaning
// IDLE  | ready for a request; ALU command is aluOFF
// ISSUE | command and operands presented for the ALU to sample
// WAIT  | holding command while alu_busy is high; timeout counter running
// RESP  | response presented until rsp_ready

module alu_driver #(
   parameter int width   = 36,
   parameter int TIMEOUT = 64
) (
   input  logic                      clk,
   input  logic                      reset,
`ifdef ALU_DRIVER_STICKY_FLAGS_EN
   input  logic                      flags_clear,
   output logic                      sticky_overflow,
   output logic                      sticky_carry0,
   output logic                      sticky_carry1,
`endif
   input  logic                      req_valid,
   output logic                      req_ready,
   input  logic [`aluCMDwidth-1:0]   req_cmd,
   input  logic [width-1:0]          req_op1high,
   input  logic [width-1:0]          req_op1,
   input  logic [width-1:0]          req_op2,
   output logic [`aluCMDwidth-1:0]   alu_command,
   output logic [width-1:0]          alu_op1high,
   output logic [width-1:0]          alu_op1,
   output logic [width-1:0]          alu_op2,
   input  logic [width-1:0]          alu_resulthigh,
   input  logic [width-1:0]          alu_resultlow,
   input  logic                      alu_overflow,
   input  logic                      alu_carry0,
   input  logic                      alu_carry1,
   input  logic                      alu_zero,
   input  logic                      alu_busy,
   output logic                      rsp_valid,
   input  logic                      rsp_ready,
   output logic [width-1:0]          rsp_resulthigh,
   output logic [width-1:0]          rsp_resultlow,
   output logic                      rsp_overflow,
   output logic                      rsp_carry0,
   output logic                      rsp_carry1,
   output logic                      rsp_zero,
   output logic                      rsp_error
);

   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   state_t          state_q;
   state_t          state_d;
   logic [CW-1:0]   tmo_cnt;
   logic            accept;
   logic            req_is_off;
   logic            wait_done;
   logic            tmo_hit;

   assign req_is_off = (req_cmd == `aluOFF);
   assign accept     = (state_q == IDLE) && req_valid;
   assign wait_done  = (state_q == WAIT) && !alu_busy;
   // abort on the busy edge that would bring the count up to TIMEOUT
   assign tmo_hit    = (state_q == WAIT) && alu_busy && (tmo_cnt == TMO_LAST);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (req_valid) state_d = req_is_off ? RESP : ISSUE;
         ISSUE:   state_d = WAIT;
         WAIT:    if (wait_done || tmo_hit) state_d = RESP;
         RESP:    if (rsp_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      req_ready = (state_q == IDLE);
      rsp_valid = (state_q == RESP);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)                                   tmo_cnt <= '0;
      else if (state_q == ISSUE)                    tmo_cnt <= '0;
      else if ((state_q == WAIT) && alu_busy && !tmo_hit) tmo_cnt <= tmo_cnt + 1'b1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         alu_command    <= `aluOFF;
         alu_op1high    <= '0;
         alu_op1        <= '0;
         alu_op2        <= '0;
         rsp_resulthigh <= '0;
         rsp_resultlow  <= '0;
         rsp_overflow   <= 1'b0;
         rsp_carry0     <= 1'b0;
         rsp_carry1     <= 1'b0;
         rsp_zero       <= 1'b0;
         rsp_error      <= 1'b0;
      end else if (accept) begin
         rsp_error <= 1'b0;
         if (req_is_off) begin
            // no-op request: answer immediately, leave the ALU untouched
            rsp_resulthigh <= '0;
            rsp_resultlow  <= '0;
            rsp_overflow   <= 1'b0;
            rsp_carry0     <= 1'b0;
            rsp_carry1     <= 1'b0;
            rsp_zero       <= 1'b0;
         end else begin
            alu_command <= req_cmd;
            alu_op1high <= req_op1high;
            alu_op1     <= req_op1;
            alu_op2     <= req_op2;
         end
      end else if (wait_done) begin
         alu_command    <= `aluOFF;
         rsp_resulthigh <= alu_resulthigh;
         rsp_resultlow  <= alu_resultlow;
         rsp_overflow   <= alu_overflow;
         rsp_carry0     <= alu_carry0;
         rsp_carry1     <= alu_carry1;
         rsp_zero       <= alu_zero;
      end else if (tmo_hit) begin
         alu_command    <= `aluOFF;
         rsp_resulthigh <= '0;
         rsp_resultlow  <= '0;
         rsp_overflow   <= 1'b0;
         rsp_carry0     <= 1'b0;
         rsp_carry1     <= 1'b0;
         rsp_zero       <= 1'b0;
         rsp_error      <= 1'b1;
      end
   end

`ifdef ALU_DRIVER_STICKY_FLAGS_EN
   logic [2:0] sticky_q;
   logic [2:0] sticky_base;

   // clear and capture on the same edge: clear first, then OR the new flags in
   assign sticky_base = flags_clear ? 3'b000 : sticky_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)         sticky_q <= 3'b000;
      else if (wait_done) sticky_q <= sticky_base | {alu_overflow, alu_carry0, alu_carry1};
      else                sticky_q <= sticky_base;
   end

   assign sticky_overflow = sticky_q[2];
   assign sticky_carry0   = sticky_q[1];
   assign sticky_carry1   = sticky_q[0];
`endif

endmodule

// File: tb/tb_alu_driver.sv
// Directed bench for alu_driver: an ALU stub with programmable busy length, a response model
// queue checked every cycle the response is valid, and literal expectations per test.
`timescale 1ns/1ps

`ifndef aluCMDwidth
`define aluCMDwidth 5
`endif
`ifndef aluOFF
`define aluOFF 5'd0
`endif

module tb_alu_driver;
   localparam int W   = 36;
   localparam int TMO = 8;
   localparam logic [4:0] C_OFF = `aluOFF;
   localparam logic [4:0] C_ADD = 5'd1;
   localparam logic [4:0] C_SUB = 5'd2;
   localparam logic [4:0] C_LSH = 5'd3;

   typedef struct packed {
      logic [W-1:0] hi;
      logic [W-1:0] lo;
      logic         ov;
      logic         c0;
      logic         c1;
      logic         z;
      logic         err;
   } rsp_t;

   logic         clk = 1'b0;
   logic         reset = 1'b0;
   logic         req_valid = 1'b0;
   logic         req_ready;
   logic [4:0]   req_cmd = C_OFF;
   logic [W-1:0] req_op1high = '0, req_op1 = '0, req_op2 = '0;
   logic [4:0]   alu_command;
   logic [W-1:0] alu_op1high, alu_op1, alu_op2;
   logic [W-1:0] alu_resulthigh, alu_resultlow;
   logic         alu_overflow, alu_carry0, alu_carry1, alu_zero, alu_busy;
   logic         rsp_valid;
   logic         rsp_ready = 1'b0;
   logic [W-1:0] rsp_resulthigh, rsp_resultlow;
   logic         rsp_overflow, rsp_carry0, rsp_carry1, rsp_zero, rsp_error;
`ifdef ALU_DRIVER_STICKY_FLAGS_EN
   logic         flags_clear = 1'b0;
   logic         sticky_overflow, sticky_carry0, sticky_carry1;
`endif

   int   total_cnt = 0;
   int   pass_cnt  = 0;
   rsp_t expq[$];
   rsp_t last_rsp;
   int   last_lat;
   int   busy_n = 0;
   int   busy_cnt = 0;
   logic started = 1'b0;

   always #5 clk = ~clk;

   alu_driver #(.width(W), .TIMEOUT(TMO)) dut (
      .clk(clk), .reset(reset),
`ifdef ALU_DRIVER_STICKY_FLAGS_EN
      .flags_clear(flags_clear), .sticky_overflow(sticky_overflow),
      .sticky_carry0(sticky_carry0), .sticky_carry1(sticky_carry1),
`endif
      .req_valid(req_valid), .req_ready(req_ready), .req_cmd(req_cmd),
      .req_op1high(req_op1high), .req_op1(req_op1), .req_op2(req_op2),
      .alu_command(alu_command), .alu_op1high(alu_op1high), .alu_op1(alu_op1), .alu_op2(alu_op2),
      .alu_resulthigh(alu_resulthigh), .alu_resultlow(alu_resultlow),
      .alu_overflow(alu_overflow), .alu_carry0(alu_carry0), .alu_carry1(alu_carry1),
      .alu_zero(alu_zero), .alu_busy(alu_busy),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_resulthigh(rsp_resulthigh), .rsp_resultlow(rsp_resultlow),
      .rsp_overflow(rsp_overflow), .rsp_carry0(rsp_carry0), .rsp_carry1(rsp_carry1),
      .rsp_zero(rsp_zero), .rsp_error(rsp_error)
   );

   // arithmetic the ALU stub performs; the high word is an arbitrary mix so its transport is visible
   function automatic rsp_t alu_fn(input logic [4:0] cmd, input logic [W-1:0] h, a, b);
      rsp_t       r;
      logic [W:0] s;
      r = '0;
      s = '0;
      case (cmd)
         C_ADD: begin
            s = {1'b0, a} + {1'b0, b};
            r.lo = s[W-1:0]; r.c0 = s[W]; r.c1 = a[W-1] ^ b[W-1] ^ s[W-1]; r.ov = r.c0 ^ r.c1;
         end
         C_SUB: begin
            s = {1'b0, a} + {1'b0, ~b} + 37'd1;
            r.lo = s[W-1:0]; r.c0 = s[W]; r.c1 = a[W-1] ^ ~b[W-1] ^ s[W-1]; r.ov = r.c0 ^ r.c1;
         end
         C_LSH: r.lo = a << b[7:0];
         default: ;
      endcase
      if (cmd != C_OFF) begin
         r.hi = h ^ b;
         r.z  = (r.lo == '0);
      end
      return r;
   endfunction

   rsp_t stub;
   assign stub           = alu_fn(alu_command, alu_op1high, alu_op1, alu_op2);
   assign alu_resulthigh = stub.hi;
   assign alu_resultlow  = stub.lo;
   assign alu_overflow   = stub.ov;
   assign alu_carry0     = stub.c0;
   assign alu_carry1     = stub.c1;
   assign alu_zero       = stub.z;
   assign alu_busy       = started && (busy_cnt > 0);

   // busy stays high for busy_n cycles once the ALU has sampled a new command
   always @(posedge clk) begin
      if (alu_command == C_OFF) started <= 1'b0;
      else if (!started) begin
         started  <= 1'b1;
         busy_cnt <= busy_n;
      end else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
   end

   task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   initial begin
      forever begin
         @(negedge clk);
         if (reset && rsp_valid) begin
            if (expq.size() == 0) check("rsp_valid_unexpected", rsp_valid, 0);
            else begin
               check("rsp_hi",    rsp_resulthigh, expq[0].hi);
               check("rsp_lo",    rsp_resultlow,  expq[0].lo);
               check("rsp_flags", {rsp_overflow, rsp_carry0, rsp_carry1, rsp_zero},
                                  {expq[0].ov, expq[0].c0, expq[0].c1, expq[0].z});
               check("rsp_error", rsp_error, expq[0].err);
               check("req_ready_in_resp", req_ready, 0);
            end
         end
      end
   end

   task automatic do_op(input logic [4:0] cmd, input logic [W-1:0] h, a, b,
                        input int bn, input int rdly);
      rsp_t e;
      int   exp_lat;
      int   n;
      e = alu_fn(cmd, h, a, b);
      if (cmd == C_OFF) exp_lat = 0;
      else if (bn >= TMO) begin
         exp_lat = TMO + 1;
         e = '0;
         e.err = 1'b1;
      end else exp_lat = 2 + bn;
      busy_n = bn;
      @(negedge clk);
      req_valid = 1'b1; req_cmd = cmd; req_op1high = h; req_op1 = a; req_op2 = b;
      n = 0;
      while (!req_ready && n < 50) begin @(negedge clk); n++; end
      check("req_ready_idle", req_ready, 1);
      @(posedge clk);
      expq.push_back(e);
      #1;
      req_valid = 1'b0; req_cmd = C_SUB; req_op1high = '1; req_op1 = '1; req_op2 = 36'h5A5;
      n = 0;
      while (!rsp_valid && n < 200) begin
         check("alu_cmd_held", alu_command, cmd);
         check("alu_op1_held", alu_op1, a);
         check("alu_op2_held", alu_op2, b);
         @(posedge clk); #1;
         n++;
      end
      last_lat = n;
      check("latency", n, exp_lat);
      check("alu_cmd_off_at_rsp", alu_command, C_OFF);
      last_rsp = '{rsp_resulthigh, rsp_resultlow, rsp_overflow, rsp_carry0, rsp_carry1,
                   rsp_zero, rsp_error};
      repeat (rdly) @(posedge clk);
      @(negedge clk);
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      if (expq.size() > 0) void'(expq.pop_front());
      check("rsp_valid_dropped", rsp_valid, 0);
      check("req_ready_back", req_ready, 1);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      #12;
      check("rst_alu_command", alu_command, C_OFF);
      check("rst_rsp_valid",   rsp_valid, 0);
      check("rst_req_ready",   req_ready, 1);
      check("rst_alu_op1",     alu_op1, 0);
      check("rst_rsp_lo",      rsp_resultlow, 0);
      check("rst_rsp_error",   rsp_error, 0);
      @(negedge clk);
      reset = 1'b1;

      do_op(C_ADD, 36'd0, 36'd7, 36'd13, 0, 0);
      check("add_lo",   last_rsp.lo, 36'd20);
      check("add_zero", last_rsp.z, 0);
      check("add_err",  last_rsp.err, 0);
      check("add_lat",  last_lat, 2);

      do_op(C_ADD, 36'd0, 36'o377777777777, 36'd1, 0, 0);
      check("ovf_lo", last_rsp.lo, 36'o400000000000);
      check("ovf_ov", last_rsp.ov, 1);
      check("ovf_c1", last_rsp.c1, 1);
      check("ovf_c0", last_rsp.c0, 0);

      do_op(C_LSH, 36'o1234, 36'o000004000000, 36'd2, 3, 0);
      check("lsh_lo",  last_rsp.lo, 36'o000020000000);
      check("lsh_hi",  last_rsp.hi, 36'o1236);
      check("lsh_lat", last_lat, 5);

      do_op(C_SUB, 36'd0, 36'd3, 36'd3, 0, 5);
      check("sub_zero", last_rsp.z, 1);

      do_op(C_ADD, 36'd0, 36'd9, 36'd9, 1000, 0);
      check("tmo_err", last_rsp.err, 1);
      check("tmo_lo",  last_rsp.lo, 0);
      check("tmo_lat", last_lat, TMO + 1);

      do_op(C_ADD, 36'd0, 36'd100, 36'd200, TMO - 1, 1);
      check("near_tmo_lo",  last_rsp.lo, 36'd300);
      check("near_tmo_err", last_rsp.err, 0);
      check("near_tmo_lat", last_lat, TMO + 1);

      do_op(C_OFF, 36'd3, 36'd4, 36'd5, 0, 2);
      check("off_lo",  last_rsp.lo, 0);
      check("off_lat", last_lat, 0);

      busy_n = 1000;
      @(negedge clk);
      req_valid = 1'b1; req_cmd = C_ADD; req_op1 = 36'd5; req_op2 = 36'd6;
      @(posedge clk); #1;
      req_valid = 1'b0;
      repeat (4) @(posedge clk);
      #2 reset = 1'b0;
      #1;
      check("midrst_alu_command", alu_command, C_OFF);
      check("midrst_rsp_valid",   rsp_valid, 0);
      check("midrst_req_ready",   req_ready, 1);
      check("midrst_alu_op1",     alu_op1, 0);
      @(negedge clk);
      reset = 1'b1;

      do_op(C_SUB, 36'd0, 36'd10, 36'd4, 0, 0);
      check("post_rst_lo", last_rsp.lo, 36'd6);

`ifdef ALU_DRIVER_STICKY_FLAGS_EN
      do_op(C_ADD, 36'd0, 36'o377777777777, 36'd1, 0, 0);
      check("sticky_ov_1", sticky_overflow, 1);
      do_op(C_ADD, 36'd0, 36'o377777777777, 36'd2, 0, 0);
      check("sticky_ov_2", sticky_overflow, 1);
      @(negedge clk);
      flags_clear = 1'b1;
      @(posedge clk); #1;
      flags_clear = 1'b0;
      check("sticky_ov_clr", sticky_overflow, 0);
`endif

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
